rf_write_scheduler: RTL and testbench
=====================================

// Module: rf_write_scheduler
// PURPOSE
//  Owns the single write port (A3/WE3/WD3) of the 8x32 register file and shares it
//  between two writeback requesters. Requester 0 is ALU writeback; requester 1 is
//  load writeback. Arbitration is round-robin with a valid/ready handshake.
//  A clear sequencer zeroes every register after reset and on a CLR_REQ pulse.
//  Sits between the writeback stage and registerFile; RD1/RD2 reads are not touched.
// PARAMETERS
//  DATA_W          32  write data width
//  ADDR_W          5   requester/A3 address width
//  NREGS           8   implemented registers; legal addresses are 0..NREGS-1
//  CLEAR_ON_RESET  1   1: enter CLEAR after reset release; 0: enter ARB directly
// PORTS
//  CLK         in   1       clock, rising edge
//  RSTN        in   1       asynchronous active-low reset
//  CLR_REQ     in   1       one-cycle pulse requesting a soft clear of all registers
//  REQ0_VALID  in   1       requester 0 has a write pending
//  REQ0_ADDR   in   ADDR_W  requester 0 destination register
//  REQ0_DATA   in   DATA_W  requester 0 write data
//  REQ0_READY  out  1       requester 0 write accepted this cycle (combinational)
//  REQ1_VALID/REQ1_ADDR/REQ1_DATA/REQ1_READY   same as requester 0
//  A3          out  ADDR_W  register file write address (registered)
//  WE3         out  1       register file write enable (registered)
//  WD3         out  DATA_W  register file write data (registered)
//  BUSY        out  1       clear sequence in progress
//  ERR         out  1       1-cycle pulse: an accepted address was >= NREGS
// BEHAVIOUR
//  Reset (RSTN=0, async):
//   A3=0, WE3=0, WD3=0, READY0/1=0, ERR=0, clear index=0.
//   BUSY=CLEAR_ON_RESET. Round-robin pointer last_grant=1, so req0 has first priority.
//  FSM states: CLEAR, ARB.
//   After reset the FSM is in CLEAR if CLEAR_ON_RESET=1, otherwise in ARB.
//  CLEAR:
//   READY0/1=0 and BUSY=1.
//   Each cycle, register A3<=idx, WD3<=0, WE3<=1, idx<=idx+1.
//   After the cycle that issues idx=NREGS-1, the FSM goes to ARB with idx=0.
//   Clearing NREGS registers takes exactly NREGS cycles.
//   CLR_REQ pulses received while in CLEAR are ignored (no restart, no queueing).
//  ARB:
//   BUSY=0.
//   If CLR_REQ=1, go to CLEAR. Both READYs are 0 that cycle; clear beats any valid request.
//   Else, if only one VALID is high, that requester gets READY=1.
//   Else, if both are high, the requester != last_grant gets READY=1 and the other waits.
//   A transfer occurs when VALID and READY are both high. On a transfer:
//    last_grant<=id; A3<=addr; WD3<=data; WE3<=(addr<NREGS); ERR<=(addr>=NREGS).
//   Cycles with no transfer and no clear: WE3<=0, ERR<=0. A3/WD3 hold.
//  Latency:
//   A request accepted in cycle N drives WE3=1 during cycle N+1.
//   The register file captures it at the end of cycle N+1.
//   Sustained throughput is one write per cycle.
//  Handshake:
//   READY depends only on VALIDs, CLR_REQ, state and last_grant. READY never depends on ADDR or DATA.
//   A requester holds VALID/ADDR/DATA stable until accepted; the scheduler does not buffer.
//  Boundary conditions:
//   Both requesters targeting the same register in consecutive cycles: both writes issue in grant order; the last one wins.
//   Address 0 is an ordinary writable register.
//   Only ADDR bits below clog2(NREGS) reach registerFile decoding; out-of-range writes are suppressed, never aliased.
//   RSTN asserted mid-CLEAR or mid-write: all state returns to reset values immediately.
//    With CLEAR_ON_RESET=1, the clear restarts at idx 0 after release.
// TESTING
//  1) Reset release, CLEAR_ON_RESET=1 -> BUSY=1 for 8 cycles; WE3=1 with A3=0..7, WD3=0; then BUSY=0.
//  2) REQ0 only, addr 3, data 0xDEADBEEF -> READY0 same cycle; next cycle WE3=1, A3=3, WD3=0xDEADBEEF.
//  3) Both VALID held for 4 cycles, after reset -> grants 0,1,0,1; WE3 high 4 consecutive cycles.
//  4) CLR_REQ and REQ1_VALID in the same cycle in ARB -> READY1=0; 8 clear writes; then REQ1 is granted.
//  5) REQ0 addr 9 -> accepted; next cycle WE3=0 and ERR=1 for exactly one cycle.
//  6) RSTN low during the 4th CLEAR cycle -> outputs reset at once; after release the clear resumes from A3=0.

Source files
------------

// File: rtl/rf_write_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_scheduler_if
// Purpose  : Writeback-side bundle for rf_write_scheduler: two requester
//            valid/ready channels, soft-clear pulse, and the register file
//            write port (A3/WE3/WD3) with status flags.
// Revision : 1.0 - initial release
// ============================================================================
interface rf_write_scheduler_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              clr_req;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] a3;
  logic              we3;
  logic [DATA_W-1:0] wd3;
  logic              busy;
  logic              err;

  // Writeback side: raises requests and observes the write port.
  modport master (
    output clr_req,
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  a3, we3, wd3, busy, err
  );

  // Scheduler side: accepts requests and drives the write port.
  modport slave (
    input  clr_req,
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output a3, we3, wd3, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : rf_write_scheduler
// Purpose  : Shares the single register file write port between ALU (req0)
//            and load (req1) writeback with round-robin arbitration, and
//            zeroes every register after reset and on a soft-clear pulse.
// Revision : 1.0 - initial release
// ============================================================================
module rf_write_scheduler #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter int NREGS          = 8,
  parameter int CLEAR_ON_RESET = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  rf_write_scheduler_if.slave bus
);

  localparam int                  c_IDX_W    = (NREGS > 1) ? $clog2(NREGS) : 1;
  localparam logic [c_IDX_W-1:0]  c_LAST_IDX = c_IDX_W'(NREGS - 1);
  // One extra bit so NREGS itself is representable for the range compare.
  localparam logic [ADDR_W:0]     c_NREGS    = (ADDR_W + 1)'(NREGS);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  localparam state_t c_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;

  state_t              r_state;
  logic [c_IDX_W-1:0]  r_idx;
  logic                r_last_grant;   // 1: req1 was granted last
  logic [ADDR_W-1:0]   r_a3;
  logic                r_we3;
  logic [DATA_W-1:0]   r_wd3;
  logic                r_err;

  logic                w_arb;
  logic                w_gnt0;
  logic                w_gnt1;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;
  logic                w_in_range;

  // Grants depend only on valids, clear request, state and last grant;
  // the reset term keeps both READYs low while reset is asserted.
  assign w_arb      = rst_n && (r_state == ST_ARB) && !bus.clr_req;
  assign w_gnt0     = w_arb && bus.req0_valid && (!bus.req1_valid || r_last_grant);
  assign w_gnt1     = w_arb && bus.req1_valid && (!bus.req0_valid || !r_last_grant);
  assign w_sel_addr = w_gnt1 ? bus.req1_addr : bus.req0_addr;
  assign w_sel_data = w_gnt1 ? bus.req1_data : bus.req0_data;
  // Out-of-range writes are dropped rather than aliased onto a low register.
  assign w_in_range = ({1'b0, w_sel_addr} < c_NREGS);

  assign bus.req0_ready = w_gnt0;
  assign bus.req1_ready = w_gnt1;
  assign bus.a3         = r_a3;
  assign bus.we3        = r_we3;
  assign bus.wd3        = r_wd3;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state == ST_CLEAR);

  // Clear sequencer / arbiter FSM with registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_RST_STATE;
      r_idx        <= '0;
      r_last_grant <= 1'b1;
      r_a3         <= '0;
      r_we3        <= 1'b0;
      r_wd3        <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          // Clear pulses are ignored here: the sweep never restarts.
          r_a3  <= ADDR_W'(r_idx);
          r_wd3 <= '0;
          r_we3 <= 1'b1;
          r_err <= 1'b0;
          if (r_idx == c_LAST_IDX) begin
            r_idx   <= '0;
            r_state <= ST_ARB;
          end else begin
            r_idx <= r_idx + c_IDX_W'(1);
          end
        end
        ST_ARB: begin
          if (bus.clr_req) begin
            r_state <= ST_CLEAR;
            r_idx   <= '0;
            r_we3   <= 1'b0;
            r_err   <= 1'b0;
          end else if (w_gnt0 || w_gnt1) begin
            r_last_grant <= w_gnt1;
            r_a3         <= w_sel_addr;
            r_wd3        <= w_sel_data;
            r_we3        <= w_in_range;
            r_err        <= !w_in_range;
          end else begin
            r_we3 <= 1'b0;
            r_err <= 1'b0;
          end
        end
        default: begin
          r_state <= c_RST_STATE;
          r_idx   <= '0;
          r_we3   <= 1'b0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_write_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_write_scheduler
// Purpose  : Self-checking bench for rf_write_scheduler: directed scenarios
//            followed by randomized traffic against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rf_write_scheduler;

  localparam int c_NREGS = 8;

  logic clk;
  logic rst_n;

  rf_write_scheduler_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  rf_write_scheduler #(
    .DATA_W(32), .ADDR_W(5), .NREGS(c_NREGS), .CLEAR_ON_RESET(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: a clear is "NREGS writes of zero to 0,1,2,..."; otherwise
  // the requester that was not served last wins a tie.
  bit          m_clearing;
  int          m_idx;
  int          m_last;
  logic [4:0]  m_a3;
  logic        m_we3;
  logic [31:0] m_wd3;
  logic        m_err;
  logic [31:0] m_rf  [c_NREGS];
  logic [31:0] rf_obs[c_NREGS];

  // Requester state: each holds its request until accepted.
  bit          p_v[2];
  logic [4:0]  p_a[2];
  logic [31:0] p_d[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_clearing = 1'b1;
    m_idx      = 0;
    m_last     = 1;
    m_a3       = '0;
    m_we3      = 1'b0;
    m_wd3      = '0;
    m_err      = 1'b0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".a3"},   64'(bus.a3),   64'(m_a3));
    check({tag, ".we3"},  64'(bus.we3),  64'(m_we3));
    check({tag, ".wd3"},  64'(bus.wd3),  64'(m_wd3));
    check({tag, ".err"},  64'(bus.err),  64'(m_err));
    check({tag, ".busy"}, 64'(bus.busy), 64'(m_clearing));
    if (bus.we3 === 1'b1) rf_obs[bus.a3[2:0]] = bus.wd3;
  endtask

  // One clock: present requests, check READYs, advance model, check outputs.
  task automatic step(input string tag, input bit clr, output int g);
    bus.clr_req    = clr;
    bus.req0_valid = p_v[0]; bus.req0_addr = p_a[0]; bus.req0_data = p_d[0];
    bus.req1_valid = p_v[1]; bus.req1_addr = p_a[1]; bus.req1_data = p_d[1];
    #1;
    g = -1;
    if (!m_clearing && !clr) begin
      if (p_v[0] && p_v[1]) g = (m_last == 0) ? 1 : 0;
      else if (p_v[0])      g = 0;
      else if (p_v[1])      g = 1;
    end
    check({tag, ".ready0"}, 64'(bus.req0_ready), 64'(g == 0));
    check({tag, ".ready1"}, 64'(bus.req1_ready), 64'(g == 1));
    if (m_clearing) begin
      m_a3 = 5'(m_idx); m_wd3 = '0; m_we3 = 1'b1; m_err = 1'b0;
      m_rf[m_idx] = '0;
      m_idx++;
      if (m_idx == c_NREGS) begin m_clearing = 1'b0; m_idx = 0; end
    end else if (clr) begin
      m_clearing = 1'b1; m_idx = 0; m_we3 = 1'b0; m_err = 1'b0;
    end else if (g >= 0) begin
      m_last = g;
      m_a3   = p_a[g];
      m_wd3  = p_d[g];
      m_we3  = (int'(p_a[g]) < c_NREGS);
      m_err  = !m_we3;
      if (m_we3) m_rf[p_a[g]] = p_d[g];
      p_v[g] = 1'b0;
    end else begin
      m_we3 = 1'b0; m_err = 1'b0;
    end
    @(posedge clk); #1;
    check_outputs(tag);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset(input string tag);
    #2;
    rst_n = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; bus.clr_req = 1'b0;
    #1;
    model_reset();
    check_outputs(tag);
    check({tag, ".ready0"}, 64'(bus.req0_ready), 64'd0);
    check({tag, ".ready1"}, 64'(bus.req1_ready), 64'd0);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int id, input logic [4:0] a, input logic [31:0] d);
    p_v[id] = 1'b1; p_a[id] = a; p_d[id] = d;
  endtask

  task automatic idle_cycles(input string tag, input int n);
    int g;
    for (int i = 0; i < n; i++) step(tag, 1'b0, g);
  endtask

  initial begin
    int g;
    int seq[$];
    rst_n = 1'b0;
    bus.clr_req = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    for (int i = 0; i < c_NREGS; i++) begin m_rf[i] = 'x; rf_obs[i] = 'x; end
    model_reset();
    #1;
    check_outputs("reset");
    #11;
    rst_n = 1'b1;

    // Power-up clear: eight zero writes to 0..7, then idle.
    idle_cycles("clear_pwr", c_NREGS + 1);

    // Single ALU write.
    set_req(0, 5'd3, 32'hDEADBEEF);
    step("req0_only", 1'b0, g);
    check("req0_only.grant", 64'(g), 64'd0);

    // Fresh reset, then both requesters held: grants alternate from req0.
    pulse_reset("rst2");
    idle_cycles("clear2", c_NREGS);
    for (int i = 0; i < 4; i++) begin
      if (!p_v[0]) set_req(0, 5'(i), 32'h1000_0000 + 32'(i));
      if (!p_v[1]) set_req(1, 5'(i + 4), 32'h2000_0000 + 32'(i));
      step("both_valid", 1'b0, g);
      seq.push_back(g);
    end
    foreach (seq[i]) check("both_valid.order", 64'(seq[i]), 64'(i % 2));
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    idle_cycles("drain", 1);

    // Clear beats a pending load writeback, which is served after the sweep.
    set_req(1, 5'd6, 32'hCAFE_F00D);
    step("clr_vs_req1", 1'b1, g);
    for (int i = 0; i < c_NREGS; i++) step("clr_sweep", (i == 2), g);
    step("req1_after_clr", 1'b0, g);
    check("req1_after_clr.grant", 64'(g), 64'd1);

    // Out-of-range address: accepted, write suppressed, one-cycle ERR.
    set_req(0, 5'd9, 32'h1234_5678);
    step("oor", 1'b0, g);
    idle_cycles("oor_after", 1);

    // Same register from both requesters: last granted one wins.
    set_req(0, 5'd5, 32'hAAAA_0000);
    set_req(1, 5'd5, 32'hBBBB_0000);
    idle_cycles("same_reg", 3);

    // Reset during the fourth clear cycle; sweep restarts at register 0.
    step("clr_req", 1'b1, g);
    idle_cycles("clr_part", 3);
    pulse_reset("rst_mid_clear");
    idle_cycles("clear_restart", c_NREGS + 1);

    // Randomized traffic with occasional clears and resets.
    for (int cyc = 0; cyc < 2000; cyc++) begin
      for (int r = 0; r < 2; r++) begin
        if (!p_v[r] && ($urandom_range(0, 99) < 60))
          set_req(r, 5'($urandom_range(0, 9)), $urandom);
      end
      if ($urandom_range(0, 599) == 0) pulse_reset("rnd_rst");
      step("rnd", ($urandom_range(0, 99) < 2), g);
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    idle_cycles("final", c_NREGS + 2);

    for (int i = 0; i < c_NREGS; i++) check($sformatf("rf[%0d]", i), 64'(rf_obs[i]), 64'(m_rf[i]));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
